hermes_input_buffer: RTL
========================

# hermes_input_buffer

Per-port input buffer and packet sequencer for the Hermes router. It stores incoming flits in a circular FIFO and raises a routing request to the switch control. Once granted, it streams the packet (header, size, payload) through the crossbar, holding the switch's sending indication for the packet's duration. One instance sits on each of the NPORT input ports, paired with the switch's req/ack/sending signals for that port.

## Interface
- FLIT_SIZE, 32: flit width in bits; minimum 20.
- BUFFER_SIZE, 8: FIFO depth in flits; power of two, minimum 4.

- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- rx_i  in  1  upstream flit valid
- data_i  in  FLIT_SIZE  upstream flit
- credit_o  out  1  FIFO not full; upstream may send
- req_o  out  1  routing request to switch control
- ack_i  in  1  one-cycle routing grant from switch control
- sending_o  out  1  packet in transit; falling edge frees the switch output port
- tx_o  out  1  head flit valid toward the crossbar
- data_o  out  FLIT_SIZE  head flit of the FIFO
- credit_i  in  1  downstream accepts a flit this cycle

## Operation
- Packet format:
  - flit 0 is the header, with the target in [15:0].
  - flit 1 is the size, N = number of payload flits, unsigned FLIT_SIZE bits.
  - flits 2..N+1 are the payload.
  - N = 0 is legal.
- FIFO behaviour:
  - Push when rx_i && credit_o.
  - Pop when tx_o && credit_i.
  - Pointers are $clog2(BUFFER_SIZE) bits plus a wrap bit.
  - Full is indicated by equal index and differing wrap bit; empty by both equal.
  - The pointers wrap from BUFFER_SIZE-1 to 0.
- rx_i while full is a protocol violation: the flit is dropped and the pointers are unchanged.
- Simultaneous push and pop are both performed and the count is unchanged.
- There is no bypass: a flit pushed into an empty FIFO is visible on data_o one cycle later.
- FSM states:
  - S_IDLE: go to S_REQ when the FIFO is not empty.
  - S_REQ: req_o = 1. Go to S_HEADER when ack_i = 1.
  - S_HEADER: on pop, go to S_SIZE.
  - S_SIZE: on pop, load cnt = data_o. Go to S_IDLE if data_o == 0, else go to S_PAYLOAD.
  - S_PAYLOAD: on pop, cnt decrements. On the pop where cnt == 1, go to S_IDLE.
- tx_o = (state in {S_HEADER, S_SIZE, S_PAYLOAD}) && !empty.
- sending_o is a register:
  - Set on the ack_i edge.
  - Cleared on the edge that pops the last flit (size flit when N = 0, otherwise the final payload flit).
- The FIFO accepts flits of the next packet while the current packet drains. The next request is raised only after the return to S_IDLE.
- ack_i outside S_REQ is ignored.

## Timing
- Reset values: credit_o = 1, req_o = 0, sending_o = 0, tx_o = 0, data_o = 0. Storage is cleared to 0, pointers to 0, cnt to 0, state to S_IDLE.
- Latency:
  - First flit pushed at edge k.
  - State is S_REQ after edge k+1, so req_o is high in cycle k+1.
- req_o is held until ack_i is seen. It falls in the cycle after the ack_i cycle.
- Header pop: earliest in the cycle after ack_i, given credit_i = 1.
- Sustained throughput is one flit per cycle with credit_i held high.
- sending_o falls in the cycle after the last pop. It never spans two packets: there is a minimum of 2 idle cycles (S_IDLE, S_REQ) between packets.
- credit_o = !full and is combinational from the pointers.
- Reset mid-packet: all state clears asynchronously and the remainder of the packet is discarded. sending_o drops immediately.

## Structure
- HermesPkg holds NPORT and hermes_port_t, plus a new constant HERMES_BUFFER_SIZE = 8 used as the default depth.
- The FSM state enum is local to the module, one-hot encoded.
- One sub-module: hermes_fifo.
  - Contains storage, pointers, full/empty, and the push/pop rules above.
  - Parameters: FLIT_SIZE, BUFFER_SIZE.
- The top module holds the FSM, the size counter, and the sending register.

## Test plan
- Reset and idle:
  - Stimulus: reset, no traffic.
  - Required response: credit_o = 1, req_o = sending_o = tx_o = 0, data_o = 0, for 10 cycles.
- Minimal packet:
  - Stimulus: push header 0x0102, then size 0, then ack_i in the 3rd cycle of req_o, with credit_i = 1.
  - Required response:
    - Exactly 2 flits are popped.
    - sending_o is high for 2 cycles.
    - req_o is low after the ack_i cycle.
- Back-pressure and fill:
  - Stimulus: credit_i = 0, push 8 flits (header, size 6, 6 payload).
  - Required response:
    - credit_o falls after the 8th push.
    - A 9th rx_i is dropped.
    - Raising credit_i drains all 8 in order, 1 flit per cycle.
- Wrap-around:
  - Stimulus: packet with size 10 (12 flits), continuous push and pop.
  - Required response:
    - data_o matches the input order across the pointer wrap.
    - sending_o falls exactly one cycle after the 12th pop.
- Back-to-back packets:
  - Stimulus: two size-2 packets pushed contiguously.
  - Required response:
    - Second req_o is raised only after sending_o falls.
    - There is a gap of at least 2 cycles between the first packet's last pop and the second header pop.
- Reset mid-packet:
  - Stimulus: assert rst_ni low during the S_PAYLOAD state.
  - Required response:
    - sending_o = 0 and credit_o = 1 immediately.
    - After release, there is no req_o until a new flit is pushed.

Source files
------------

// File: rtl/hermes_input_buffer_pkg.sv
// Shared Hermes router definitions: port count, port identifiers and
// the default input-buffer depth.
package HermesPkg;

    localparam int NPORT              = 5;
    localparam int HERMES_BUFFER_SIZE = 8;

    typedef enum logic [2:0] {
        EAST,
        WEST,
        NORTH,
        SOUTH,
        LOCAL
    } hermes_port_t;

endpackage

// File: rtl/hermes_input_buffer_fifo.sv
// Circular flit FIFO with wrap-bit pointers; the read port shows the
// head entry directly, and pushes while full are dropped.
module hermes_fifo #(
    parameter int FLIT_SIZE   = 32,
    parameter int BUFFER_SIZE = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 push_i,
    input  logic                 pop_i,
    input  logic [FLIT_SIZE-1:0] data_i,
    output logic [FLIT_SIZE-1:0] data_o,
    output logic                 full_o,
    output logic                 empty_o
);

    localparam int AW = $clog2(BUFFER_SIZE);

    logic [FLIT_SIZE-1:0] mem_q [BUFFER_SIZE];
    logic [AW:0]          wr_q;
    logic [AW:0]          rd_q;
    logic                 do_push;
    logic                 do_pop;

    assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                     (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty_o = (wr_q == rd_q);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_q[AW-1:0]];

    // Power-of-two depth lets the index wrap for free into the wrap bit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < BUFFER_SIZE; i++) begin
                mem_q[i] <= '0;
            end
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q[AW-1:0]] <= data_i;
                wr_q                <= wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= rd_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/hermes_input_buffer.sv
// Hermes per-port input buffer: queues flits, requests a route, then
// streams header, size and payload while holding sending_o.
module hermes_input_buffer
    import HermesPkg::*;
#(
    parameter int FLIT_SIZE   = 32,
    parameter int BUFFER_SIZE = HERMES_BUFFER_SIZE
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 rx_i,
    input  logic [FLIT_SIZE-1:0] data_i,
    output logic                 credit_o,
    output logic                 req_o,
    input  logic                 ack_i,
    output logic                 sending_o,
    output logic                 tx_o,
    output logic [FLIT_SIZE-1:0] data_o,
    input  logic                 credit_i
);

    typedef enum logic [4:0] {
        S_IDLE    = 5'b00001,
        S_REQ     = 5'b00010,
        S_HEADER  = 5'b00100,
        S_SIZE    = 5'b01000,
        S_PAYLOAD = 5'b10000
    } state_e;

    state_e               state_q, state_d;
    logic [FLIT_SIZE-1:0] cnt_q, cnt_d;
    logic                 sending_q, sending_d;
    logic                 full;
    logic                 empty;
    logic                 pop;
    logic                 last;

    hermes_fifo #(
        .FLIT_SIZE  (FLIT_SIZE),
        .BUFFER_SIZE(BUFFER_SIZE)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push_i (rx_i),
        .pop_i  (pop),
        .data_i (data_i),
        .data_o (data_o),
        .full_o (full),
        .empty_o(empty)
    );

    assign credit_o  = !full;
    assign tx_o      = (state_q inside {S_HEADER, S_SIZE, S_PAYLOAD}) && !empty;
    assign pop       = tx_o && credit_i;
    assign sending_o = sending_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sending_d = sending_q;
        req_o     = 1'b0;
        last      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!empty) state_d = S_REQ;
            end
            S_REQ: begin
                req_o = 1'b1;
                if (ack_i) begin
                    state_d   = S_HEADER;
                    sending_d = 1'b1;
                end
            end
            S_HEADER: begin
                if (pop) state_d = S_SIZE;
            end
            S_SIZE: begin
                if (pop) begin
                    cnt_d = data_o;
                    if (data_o == '0) begin
                        state_d = S_IDLE;
                        last    = 1'b1;
                    end else begin
                        state_d = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (pop) begin
                    cnt_d = cnt_q - FLIT_SIZE'(1);
                    if (cnt_q == FLIT_SIZE'(1)) begin
                        state_d = S_IDLE;
                        last    = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Dropping on the final pop frees the output before the next request.
        if (last) sending_d = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            sending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sending_q <= sending_d;
        end
    end

endmodule
